// File: rtl/fetch_pc_sequencer.sv
// Program counter / fetch sequencer feeding a combinational instruction memory.
// Loads sel*STRIDE on a program select, fetches until OUT, drains, then pulses done.
module fetch_pc_sequencer #(
  parameter int unsigned STRIDE       = 100,
  parameter int unsigned NUM_PROGS    = 9,
  parameter logic [3:0]  OUT_OPCODE   = 4'b0001,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MAX_LEN      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prog_sel_valid,
  input  logic [3:0]  prog_sel,
  output logic        prog_sel_ready,
  input  logic        abort,
  input  logic        stall,
  input  logic [15:0] M_instruction,
  output logic [15:0] PCAdd_pc,
  output logic        fetch_valid,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        err_badsel
);

  localparam int unsigned PC_W  = 16;
  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
  localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt;
  logic [CNT_W-1:0] r_fcnt, w_fcnt_nxt;
  logic [DRN_W-1:0] r_dcnt, w_dcnt_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err_timeout, w_err_timeout_nxt;
  logic             r_err_badsel, w_err_badsel_nxt;

  logic             w_sel_ok;
  logic [PC_W-1:0]  w_start_pc;
  logic             w_is_out;
  logic             w_last_fetch;
  logic             w_drain_end;
  logic             w_unused;

  // Only the opcode field steers sequencing; operand bits belong to the pipeline.
  assign w_unused     = ^M_instruction[11:0];

  assign w_sel_ok     = (prog_sel != 4'd0) && (32'(prog_sel) <= NUM_PROGS);
  assign w_start_pc   = PC_W'(32'(prog_sel) * STRIDE);
  assign w_is_out     = (M_instruction[15:12] == OUT_OPCODE);
  assign w_last_fetch = (r_fcnt == CNT_W'(MAX_LEN - 1));
  assign w_drain_end  = (r_dcnt == DRN_W'(DRAIN_CYCLES - 1));

  // Next-state, next-PC and status pulse logic; abort overrides everything.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_fcnt_nxt        = r_fcnt;
    w_dcnt_nxt        = r_dcnt;
    w_done_nxt        = 1'b0;
    w_err_timeout_nxt = 1'b0;
    w_err_badsel_nxt  = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_fcnt_nxt  = '0;
      w_dcnt_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (prog_sel_valid) begin
            if (w_sel_ok) begin
              w_state_nxt = S_RUN;
              w_pc_nxt    = w_start_pc;
              w_fcnt_nxt  = '0;
            end else begin
              w_err_badsel_nxt = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!stall) begin
            w_fcnt_nxt = r_fcnt + CNT_W'(1);
            if (w_is_out) begin
              w_state_nxt = S_DRAIN;
              w_dcnt_nxt  = '0;
            end else if (w_last_fetch) begin
              w_state_nxt       = S_IDLE;
              w_fcnt_nxt        = '0;
              w_err_timeout_nxt = 1'b1;
            end else begin
              w_pc_nxt = r_pc + PC_W'(1);
            end
          end
        end
        S_DRAIN: begin
          // Drain runs on wall-clock cycles; stall does not extend it.
          if (w_drain_end) begin
            w_state_nxt = S_IDLE;
            w_dcnt_nxt  = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_dcnt_nxt = r_dcnt + DRN_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_fcnt        <= '0;
      r_dcnt        <= '0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_badsel  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_fcnt        <= w_fcnt_nxt;
      r_dcnt        <= w_dcnt_nxt;
      r_done        <= w_done_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      r_err_badsel  <= w_err_badsel_nxt;
    end
  end

  assign PCAdd_pc       = r_pc;
  assign fetch_valid    = (r_state == S_RUN) && !stall;
  assign prog_sel_ready = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign err_timeout    = r_err_timeout;
  assign err_badsel     = r_err_badsel;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: vector table, directed corner sequences and a
// randomized run against an abstract program-execution model.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_sel_valid = 1'b0;
  logic [3:0]  prog_sel = 4'd0;
  logic        abort = 1'b0;
  logic        stall = 1'b0;

  logic [15:0] m_instr, pc;
  logic        ready, fv, busy, done, tout, bad;
  logic [15:0] m_instr8, pc8;
  logic        ready8, fv8, busy8, done8, tout8, bad8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // OUT offset inside each program block; program 8 never reaches OUT.
  function automatic int out_off(input int p);
    case (p)
      1: return 7;   2: return 3;  3: return 0;
      4: return 9;   5: return 14; 6: return 5;
      7: return 11;  8: return 20; 9: return 10;
      default: return -1;
    endcase
  endfunction

  function automatic logic [15:0] mem(input logic [15:0] a);
    int ai, blk, off;
    logic [3:0] op;
    ai  = int'(a);
    blk = ai / 100;
    off = ai % 100;
    op  = 4'(2 + (ai % 14));
    if (blk >= 1 && blk <= 9 && off == out_off(blk)) op = 4'h1;
    return {op, a[11:0]};
  endfunction

  assign m_instr  = mem(pc);
  assign m_instr8 = mem(pc8);

  fetch_pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .prog_sel_valid(prog_sel_valid), .prog_sel(prog_sel),
    .prog_sel_ready(ready), .abort(abort), .stall(stall), .M_instruction(m_instr),
    .PCAdd_pc(pc), .fetch_valid(fv), .busy(busy), .done(done),
    .err_timeout(tout), .err_badsel(bad)
  );

  fetch_pc_sequencer #(.MAX_LEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .prog_sel_valid(prog_sel_valid), .prog_sel(prog_sel),
    .prog_sel_ready(ready8), .abort(abort), .stall(stall), .M_instruction(m_instr8),
    .PCAdd_pc(pc8), .fetch_valid(fv8), .busy(busy8), .done(done8),
    .err_timeout(tout8), .err_badsel(bad8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] s, input logic ab, input logic st);
    prog_sel_valid = v;
    prog_sel       = s;
    abort          = ab;
    stall          = st;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  sel;
    logic        ab;
    logic        st;
    logic [15:0] pc;
    logic        fv;
    logic        busy;
    logic        done;
    logic        bad;
    logic        tout;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input int sel, input logic ab, input logic st,
                     input int epc, input logic efv, input logic ebusy,
                     input logic edone, input logic ebad, input logic etout);
    vec_t e;
    e.v = v; e.sel = 4'(sel); e.ab = ab; e.st = st; e.pc = 16'(epc);
    e.fv = efv; e.busy = ebusy; e.done = edone; e.bad = ebad; e.tout = etout;
    vq.push_back(e);
  endtask

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  int          m_mode, m_pc, m_cnt, m_dleft;
  logic        m_done, m_bad, m_tout;
  logic        r_v, r_ab, r_st;
  int          r_sel;
  logic [15:0] m_word;

  initial begin : main
    // reset state
    set_in(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 0);       chk("rst_busy", busy, 0);   chk("rst_fv", fv, 0);
    chk("rst_ready", ready, 1); chk("rst_done", done, 0);
    chk("rst_tout", tout, 0);   chk("rst_bad", bad, 0);
    rst_n = 1'b1;

    // program 1: 100..107, drain, done
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 100 + i, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 107, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 107, 0, 0, 1, 0, 0);
    // program 9 with a 3-cycle stall at 902
    add(1, 9, 0, 0, 107, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 900, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 901, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 902, 0, 1, 0, 0, 0);
    for (int i = 2; i <= 10; i++) add(0, 0, 0, 0, 900 + i, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 910, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 910, 0, 0, 1, 0, 0);
    // bad selects 0 and 12
    add(1, 0, 0, 0, 910, 0, 0, 0, 0, 0);
    add(1, 12, 0, 0, 910, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 910, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 910, 0, 0, 0, 0, 0);
    // program 2 with an ignored select of 3 mid-run
    add(1, 2, 0, 0, 910, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 200, 1, 1, 0, 0, 0);
    add(1, 3, 0, 0, 201, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 202, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 203, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 203, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 203, 0, 0, 1, 0, 0);
    // program 4 aborted at 403, reselect 7, abort again
    add(1, 4, 0, 0, 203, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 400 + i, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 403, 1, 1, 0, 0, 0);
    add(1, 7, 0, 0, 403, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 700, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 701, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 701, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      set_in(vq[i].v, vq[i].sel, vq[i].ab, vq[i].st);
      settle();
      chk($sformatf("v%0d_pc", i), pc, vq[i].pc);
      chk($sformatf("v%0d_fv", i), fv, vq[i].fv);
      chk($sformatf("v%0d_busy", i), busy, vq[i].busy);
      chk($sformatf("v%0d_ready", i), ready, !vq[i].busy);
      chk($sformatf("v%0d_done", i), done, vq[i].done);
      chk($sformatf("v%0d_bad", i), bad, vq[i].bad);
      chk($sformatf("v%0d_tout", i), tout, vq[i].tout);
      next_cyc();
    end

    // MAX_LEN=8 instance: timeout on program 9, normal completion on program 1
    set_in(0, 0, 0, 0);
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    set_in(1, 9, 0, 0); settle(); chk("m8_idle_busy", busy8, 0); next_cyc();
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      settle(); chk("m8_pc", pc8, 900 + i); chk("m8_fv", fv8, 1); next_cyc();
    end
    settle();
    chk("m8_tout", tout8, 1); chk("m8_busy", busy8, 0); chk("m8_done", done8, 0);
    next_cyc();
    settle(); chk("m8_tout_clear", tout8, 0); next_cyc();
    begin : wait_idle
      int k;
      k = 0;
      while ((busy || busy8) && k < 40) begin next_cyc(); k++; end
      chk("wait_idle_timeout", (busy || busy8), 0);
    end
    set_in(1, 1, 0, 0); settle(); next_cyc();
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      settle(); chk("m8p1_pc", pc8, 100 + i); chk("m8p1_tout", tout8, 0); next_cyc();
    end
    for (int i = 0; i < 4; i++) begin
      settle(); chk("m8p1_drain_pc", pc8, 107); chk("m8p1_tout", tout8, 0); next_cyc();
    end
    settle(); chk("m8p1_done", done8, 1); chk("m8p1_tout", tout8, 0); next_cyc();

    // reset asserted during drain
    set_in(1, 1, 0, 0); settle(); next_cyc();
    set_in(0, 0, 0, 0);
    repeat (9) next_cyc();
    settle();
    chk("rd_in_drain_busy", busy, 1); chk("rd_in_drain_fv", fv, 0);
    rst_n = 1'b0;
    #1;
    chk("rd_pc", pc, 0); chk("rd_busy", busy, 0); chk("rd_fv", fv, 0);
    chk("rd_ready", ready, 1); chk("rd_done", done, 0);
    next_cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle(); chk("rd_no_done", done, 0); chk("rd_idle", busy, 0); next_cyc();
    end

    // randomized run against the program-execution model
    m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_dleft = 0;
    m_done = 0; m_bad = 0; m_tout = 0;
    for (int c = 0; c < 1500; c++) begin
      r_v   = ($urandom_range(0, 3) == 0);
      r_sel = int'($urandom_range(0, 12));
      r_ab  = ($urandom_range(0, 24) == 0);
      r_st  = ($urandom_range(0, 4) == 0);
      set_in(r_v, 4'(r_sel), r_ab, r_st);
      settle();
      chk("rnd_pc", pc, m_pc);
      chk("rnd_fv", fv, (m_mode == M_RUN) && !r_st);
      chk("rnd_busy", busy, m_mode != M_IDLE);
      chk("rnd_ready", ready, m_mode == M_IDLE);
      chk("rnd_done", done, m_done);
      chk("rnd_bad", bad, m_bad);
      chk("rnd_tout", tout, m_tout);
      m_done = 0; m_bad = 0; m_tout = 0;
      if (r_ab) begin
        m_mode = M_IDLE; m_cnt = 0; m_dleft = 0;
      end else if (m_mode == M_IDLE) begin
        if (r_v) begin
          if (r_sel >= 1 && r_sel <= 9) begin
            m_pc = r_sel * 100; m_cnt = 0; m_mode = M_RUN;
          end else begin
            m_bad = 1;
          end
        end
      end else if (m_mode == M_RUN) begin
        if (!r_st) begin
          m_cnt  = m_cnt + 1;
          m_word = mem(16'(m_pc));
          if (m_word[15:12] == 4'h1) begin
            m_mode = M_DRAIN; m_dleft = 4;
          end else if (m_cnt == 16) begin
            m_mode = M_IDLE; m_tout = 1;
          end else begin
            m_pc = (m_pc + 1) % 65536;
          end
        end
      end else begin
        m_dleft = m_dleft - 1;
        if (m_dleft == 0) begin
          m_mode = M_IDLE; m_done = 1;
        end
      end
      next_cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
